spike_aer_encoder: RTL and testbench

Downstream stage of a layer of LIF neurons. Each timestep it captures the layer's N spike_out bits as one frame, buffers frames in a small FIFO, and serializes each frame into address-event (AER) words, one per firing neuron. Output is a valid/ready stream feeding the next layer's spike router or the chip output port.

---
 rtl/spike_aer_encoder_if.sv | 25 ++
 rtl/spike_aer_encoder.sv | 154 +++++++++++++++
 tb/tb_spike_aer_encoder.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_aer_encoder_if.sv
// AER output stream: one neuron address (or end-of-step token) per valid/ready handshake.
// Ports: aer_addr / aer_eos / aer_valid driven by the encoder (master), aer_ready by the consumer (slave).
// Parameter ADDR_W sets the neuron address width and must match the encoder's ADDR_W.
interface spike_aer_encoder_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_eos;
  logic              aer_valid;
  logic              aer_ready;

  modport master (
    output aer_addr,
    output aer_eos,
    output aer_valid,
    input  aer_ready
  );

  modport slave (
    input  aer_addr,
    input  aer_eos,
    input  aer_valid,
    output aer_ready
  );
endinterface

// File: rtl/spike_aer_encoder.sv
// Purpose: captures one spike frame per timestep into a frame FIFO and serializes each frame into AER words.
// Latency: frame strobed at edge t is popped at edge t+1, first word valid after that edge; one idle bubble between frames.
// Backpressure: aer_ready low stalls the scanner with the word held stable; frames arriving while the FIFO is full are dropped and counted.
//
// Ports: clk, reset (sync, active high); enable gates frame capture only; spikes_in/spikes_valid frame input;
//        aer (spike_aer_encoder_if.master) output stream; fifo_level frames held; drop_count saturating drops;
//        busy = FIFO non-empty or scanner active.
// Optional build macro AER_EOS_EN: every accepted frame (including all-zero frames) ends with an EOS word.
module spike_aer_encoder #(
  parameter int N          = 8,
  parameter int ADDR_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N-1:0]         spikes_in,
  input  logic                 spikes_valid,
  spike_aer_encoder_if.master  aer,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [7:0]           drop_count,
  output logic                 busy
);

  localparam int              PTR_W    = LVL_W - 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EOS  = 2'd2;

  // State entered once a frame has no events left to emit.
`ifdef AER_EOS_EN
  localparam logic [1:0] S_DONE = S_EOS;
`else
  localparam logic [1:0] S_DONE = S_IDLE;
`endif

  logic [N-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [1:0]         state;
  logic [N-1:0]       work;

  logic               frame_ok;
  logic               accept_req;
  logic               push;
  logic               drop;
  logic               pop;
  logic               hs;
  logic [N-1:0]       work_clr;
  logic [ADDR_W-1:0]  low_idx;

  // Empty frames carry no events; they are only worth storing when they produce an EOS token.
`ifdef AER_EOS_EN
  assign frame_ok = 1'b1;
`else
  assign frame_ok = |spikes_in;
`endif

  assign accept_req = spikes_valid & enable & frame_ok;
  // Full is judged on the registered level so a same-cycle pop never admits an extra frame.
  assign push = accept_req & (fifo_level != FULL_LVL);
  assign drop = accept_req & (fifo_level == FULL_LVL);
  assign pop  = (state == S_IDLE) & (fifo_level != '0);
  assign hs   = aer.aer_valid & aer.aer_ready;

  // Lowest set bit wins: scan from the top so the last assignment is the lowest index.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (work[i]) begin
        low_idx = ADDR_W'(i);
      end
    end
  end

  // Clears exactly the lowest set bit.
  assign work_clr = work & (work - 1'b1);

  // Frame storage is not reset; only the pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= spikes_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      work  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            work  <= mem[rd_ptr];
            state <= (|mem[rd_ptr]) ? S_SCAN : S_DONE;
          end
        end
        S_SCAN: begin
          if (hs) begin
            work <= work_clr;
            if (work_clr == '0) begin
              state <= S_DONE;
            end
          end
        end
        S_EOS: begin
          if (hs) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state and the work register, never on aer_ready.
  assign aer.aer_valid = (state == S_SCAN) | (state == S_EOS);
  assign aer.aer_addr  = (state == S_SCAN) ? low_idx : '0;
`ifdef AER_EOS_EN
  assign aer.aer_eos   = (state == S_EOS);
`else
  assign aer.aer_eos   = 1'b0;
`endif

  assign busy = (fifo_level != '0) | (state != S_IDLE);

endmodule

// File: tb/tb_spike_aer_encoder.sv
module tb_spike_aer_encoder;

  localparam int N          = 8;
  localparam int ADDR_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;
  localparam int EOS_WORD   = 256;   // stream word encoding: address, or 256 for an EOS token

  logic             clk;
  logic             reset;
  logic             enable;
  logic [N-1:0]     spikes_in;
  logic             spikes_valid;
  logic [LVL_W-1:0] fifo_level;
  logic [7:0]       drop_count;
  logic             busy;

  spike_aer_encoder_if #(.ADDR_W(ADDR_W)) aer_bus ();

  spike_aer_encoder #(
    .N(N), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .spikes_in(spikes_in),
    .spikes_valid(spikes_valid),
    .aer(aer_bus),
    .fifo_level(fifo_level),
    .drop_count(drop_count),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int got[$];
  int expq[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: a frame expands into its set neuron indices in ascending order,
  // followed by an EOS token when that build option is on; empty frames vanish otherwise.
  function automatic bit frame_accepted(input logic [N-1:0] f);
`ifdef AER_EOS_EN
    return 1'b1;
`else
    return (f != '0);
`endif
  endfunction

  function automatic void expand(input logic [N-1:0] f);
    for (int i = 0; i < N; i++) begin
      if (f[i]) expq.push_back(i);
    end
`ifdef AER_EOS_EN
    expq.push_back(EOS_WORD);
`endif
  endfunction

  // Stream monitor: records handshakes and checks word stability across stalls.
  logic             prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic             prev_eos = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {aer_bus.aer_valid, aer_bus.aer_eos, aer_bus.aer_addr},
              {1'b1, prev_eos, prev_addr});
      end
      if (aer_bus.aer_valid && aer_bus.aer_ready) begin
        got.push_back(aer_bus.aer_eos ? EOS_WORD : int'(aer_bus.aer_addr));
      end
      prev_stall = aer_bus.aer_valid && !aer_bus.aer_ready;
      prev_addr  = aer_bus.aer_addr;
      prev_eos   = aer_bus.aer_eos;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [N-1:0] f);
    spikes_in    = f;
    spikes_valid = 1'b1;
    tick();
    spikes_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((busy || got.size() < expq.size()) && k < budget) begin
      tick();
      k++;
    end
    check("drain_in_budget", int'(k < budget), 1);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, got.size(), expq.size());
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      check(name, got[i], expq[i]);
    end
    got.delete();
    expq.delete();
  endtask

  typedef struct {
    logic [N-1:0]       frame;
    int                 cnt;
    logic [7:0][2:0]    addrs;   // element [0] is the first expected address
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{frame: 8'hA5, cnt: 4, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
    tbl[1] = '{frame: 8'h01, cnt: 1, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[2] = '{frame: 8'h80, cnt: 1, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[3] = '{frame: 8'hFF, cnt: 8, addrs: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    tbl[4] = '{frame: 8'h18, cnt: 2, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3}};
    tbl[5] = '{frame: 8'h00, cnt: 0, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};

    reset             = 1'b1;
    enable            = 1'b1;
    spikes_in         = '0;
    spikes_valid      = 1'b0;
    aer_bus.aer_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_valid", aer_bus.aer_valid, 0);
    check("rst_addr", aer_bus.aer_addr, 0);
    check("rst_eos", aer_bus.aer_eos, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drops", drop_count, 0);
    check("rst_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();

    // First-word latency: valid two cycles after the strobe cycle
    aer_bus.aer_ready = 1'b1;
    expand(8'hA5);
    strobe(8'hA5);
    @(negedge clk);
    check("lat_valid_t1", aer_bus.aer_valid, 0);
    check("lat_level_t1", fifo_level, 1);
    tick();
    @(negedge clk);
    check("lat_valid_t2", aer_bus.aer_valid, 1);
    check("lat_addr_t2", aer_bus.aer_addr, 0);
    check("lat_level_t2", fifo_level, 0);
    tick();
    drain(100);
    compare_stream("lat_stream");

    // Table-driven single frames with ready held high
    for (int v = 0; v < 6; v++) begin
      for (int j = 0; j < tbl[v].cnt; j++) expq.push_back(int'(tbl[v].addrs[j]));
`ifdef AER_EOS_EN
      expq.push_back(EOS_WORD);
`endif
      strobe(tbl[v].frame);
      drain(100);
      compare_stream("tbl_stream");
    end

    // Ready toggling 1,0,0,1,... across a frame
    expand(8'hA5);
    strobe(8'hA5);
    for (int c = 0; c < 40; c++) begin
      aer_bus.aer_ready = ((c % 3) == 0);
      tick();
    end
    aer_bus.aer_ready = 1'b1;
    drain(100);
    compare_stream("stall_stream");

    // Randomized traffic against the model; strobes only when room is guaranteed
    for (int c = 0; c < 400; c++) begin
      logic [N-1:0] f;
      logic en;
      aer_bus.aer_ready = ($urandom_range(0, 3) != 0);
      f  = N'($urandom);
      if ($urandom_range(0, 7) == 0) f = '0;
      en = ($urandom_range(0, 5) != 0);
      enable    = en;
      spikes_in = f;
      if ($urandom_range(0, 2) == 0 && fifo_level < LVL_W'(FIFO_DEPTH)) begin
        spikes_valid = 1'b1;
        if (en && frame_accepted(f)) expand(f);
      end else begin
        spikes_valid = 1'b0;
      end
      tick();
    end
    spikes_valid      = 1'b0;
    enable            = 1'b1;
    aer_bus.aer_ready = 1'b1;
    drain(300);
    compare_stream("rand_stream");
    check("rand_drops", drop_count, 0);

    // Overflow: ready low, six frames, sixth is dropped
    aer_bus.aer_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] f;
      f = N'(1) << k;
      if (k < 5) expand(f);
      strobe(f);
    end
    @(negedge clk);
    check("full_level", fifo_level, 4);
    check("full_drops", drop_count, 1);
    check("full_valid", aer_bus.aer_valid, 1);
    check("full_head", aer_bus.aer_addr, 0);
    tick();
    aer_bus.aer_ready = 1'b1;
    drain(200);
    compare_stream("full_stream");

    // All-zero frame
    if (frame_accepted('0)) expand('0);
    strobe(8'h00);
    @(negedge clk);
`ifdef AER_EOS_EN
    check("zero_level", fifo_level, 1);
`else
    check("zero_level", fifo_level, 0);
    check("zero_busy", busy, 0);
`endif
    check("zero_drops", drop_count, 1);
    tick();
    drain(100);
    compare_stream("zero_stream");

    // enable=0 ignores strobes while stored frames still drain
    aer_bus.aer_ready = 1'b0;
    expand(8'h03);
    strobe(8'h03);
    expand(8'h0C);
    strobe(8'h0C);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) strobe(8'hFF);
    @(negedge clk);
    check("dis_level", fifo_level, 1);
    check("dis_drops", drop_count, 1);
    check("dis_busy", busy, 1);
    tick();
    aer_bus.aer_ready = 1'b1;
    drain(100);
    @(negedge clk);
    check("dis_busy_end", busy, 0);
    check("dis_level_end", fifo_level, 0);
    tick();
    compare_stream("dis_stream");
    enable = 1'b1;

    // Reset mid-frame with a word pending
    aer_bus.aer_ready = 1'b0;
    strobe(8'hFF);
    strobe(8'h0F);
    tick();
    @(negedge clk);
    check("mid_pre_valid", aer_bus.aer_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid_valid", aer_bus.aer_valid, 0);
    check("mid_level", fifo_level, 0);
    check("mid_drops", drop_count, 0);
    check("mid_busy", busy, 0);
    tick();
    reset = 1'b0;
    got.delete();
    expq.delete();
    aer_bus.aer_ready = 1'b1;
    expand(8'h42);
    strobe(8'h42);
    drain(100);
    compare_stream("post_rst_stream");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
